sram_port_arbiter: RTL and testbench

- Shares the single-port data/instruction SRAM between three requesters: core data port (load/store), core instruction fetch, and an external boot/DMA loader.
- Sits between the RV32E core and the SRAM macro.
- Generates the core's inst_ready and routes the one-cycle-latency read data back to whichever requester issued the read.
- A starvation counter guarantees fetch progress against loader traffic.

---
 rtl/sram_port_arbiter_pkg.sv | 15 +
 rtl/arb_starve_counter.sv | 38 +++
 rtl/sram_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_sram_port_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the SRAM port arbiter: response owner
// encoding and the active-low byte-enable patterns driven onto the macro.
package sram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_DATA  = 2'd1,
    OWN_FETCH = 2'd2,
    OWN_LOAD  = 2'd3
  } owner_t;

  localparam logic [3:0] SRAM_BEN_NONE = 4'hF;
  localparam logic [3:0] SRAM_BEN_WORD = 4'h0;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive denied fetch cycles; limit flags when
// fetch must be promoted above the loader.
module arb_starve_counter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic limit
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q < LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign limit = (cnt_q >= LIMIT);

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between core data, core fetch and the boot/DMA
// loader; routes the one-cycle read data back to whoever issued the read.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int AW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_ben,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic [31:0]   d_rdata,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  input  logic          f_flush,
  output logic [31:0]   inst_rdata,
  output logic          inst_ready,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_wdata,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic [31:0]   ld_rdata,
  output logic          sram_cen,
  output logic          sram_wen,
  output logic [3:0]    sram_ben,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_din,
  input  logic [31:0]   sram_dout
);

  // Requests are masked while reset is held so no grant leaks out.
  logic   d_act, f_act, l_act;
  logic   starve_hi;
  owner_t win;
  owner_t owner_q, owner_d;
  logic   flush_q, flush_d;

  assign d_act = d_req  & rst_n;
  assign f_act = f_req  & rst_n;
  assign l_act = ld_req & rst_n;

  arb_starve_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (f_act && (win != OWN_FETCH)),
    .clr  (!f_act || (win == OWN_FETCH)),
    .limit(starve_hi)
  );

  always_comb begin
    win = OWN_NONE;
    if (d_act) begin
      win = OWN_DATA;
    end else if (f_act && starve_hi) begin
      win = OWN_FETCH;
    end else if (l_act) begin
      win = OWN_LOAD;
    end else if (f_act) begin
      win = OWN_FETCH;
    end
  end

  always_comb begin
    sram_cen  = 1'b1;
    sram_wen  = 1'b1;
    sram_ben  = SRAM_BEN_NONE;
    sram_addr = '0;
    sram_din  = '0;
    ld_gnt    = 1'b0;
    owner_d   = OWN_NONE;
    unique case (win)
      OWN_DATA: begin
        sram_cen  = 1'b0;
        sram_wen  = ~d_we;
        sram_ben  = d_we ? d_ben : SRAM_BEN_WORD;
        sram_addr = d_addr;
        sram_din  = d_we ? d_wdata : 32'h0;
        owner_d   = d_we ? OWN_NONE : OWN_DATA;
      end
      OWN_FETCH: begin
        sram_cen  = 1'b0;
        sram_ben  = SRAM_BEN_WORD;
        sram_addr = f_addr;
        owner_d   = OWN_FETCH;
      end
      OWN_LOAD: begin
        sram_cen  = 1'b0;
        sram_wen  = ~ld_we;
        sram_ben  = SRAM_BEN_WORD;
        sram_addr = ld_addr;
        sram_din  = ld_we ? ld_wdata : 32'h0;
        ld_gnt    = 1'b1;
        owner_d   = ld_we ? OWN_NONE : OWN_LOAD;
      end
      default: ;
    endcase
  end

  // Remember a flush seen in the grant cycle; one in the response cycle is
  // applied directly below.
  assign flush_d = f_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
      flush_q <= 1'b0;
    end else begin
      owner_q <= owner_d;
      flush_q <= flush_d;
    end
  end

  always_comb begin
    d_rdata    = '0;
    inst_rdata = '0;
    inst_ready = 1'b0;
    ld_rvalid  = 1'b0;
    ld_rdata   = '0;
    unique case (owner_q)
      OWN_DATA: d_rdata = sram_dout;
      OWN_FETCH: begin
        if (!flush_q && !f_flush) begin
          inst_ready = 1'b1;
          inst_rdata = sram_dout;
        end
      end
      OWN_LOAD: begin
        ld_rvalid = 1'b1;
        ld_rdata  = sram_dout;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: a request-level priority/response
// model checked every cycle, plus literal expectations per scenario.
module tb_sram_port_arbiter;

  localparam int AW = 32;
  localparam int STARVE_LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          d_req, d_we;
  logic [3:0]    d_ben;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata, d_rdata;
  logic          f_req, f_flush;
  logic [AW-1:0] f_addr;
  logic [31:0]   inst_rdata;
  logic          inst_ready;
  logic          ld_req, ld_we, ld_gnt, ld_rvalid;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_wdata, ld_rdata;
  logic          sram_cen, sram_wen;
  logic [3:0]    sram_ben;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_din, sram_dout;

  int checks = 0;
  int errors = 0;

  sram_port_arbiter #(.AW(AW), .STARVE_LIMIT(STARVE_LIMIT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .d_req(d_req), .d_we(d_we), .d_ben(d_ben), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata),
    .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush),
    .inst_rdata(inst_rdata), .inst_ready(inst_ready),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_ben(sram_ben),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: requester kind of the outstanding read (0 none, 1 data,
  // 2 fetch, 3 loader), the flush seen with that grant, and the count of
  // consecutive denied fetch cycles.
  int          m_starve = 0;
  int          m_pend   = 0;
  logic        m_pflush = 1'b0;
  int          w;
  logic        e_cen, e_wen, e_gnt, e_ir, e_lv, rd;
  logic [3:0]  e_ben;
  logic [31:0] e_addr, e_din, e_drd, e_ird, e_lrd;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_cen", sram_cen, 1'b1);
      chk("rst_wen", sram_wen, 1'b1);
      chk("rst_ben", sram_ben, 4'hF);
      chk("rst_addr", sram_addr, 32'h0);
      chk("rst_din", sram_din, 32'h0);
      chk("rst_gnt", ld_gnt, 1'b0);
      chk("rst_ir", inst_ready, 1'b0);
      chk("rst_lv", ld_rvalid, 1'b0);
      chk("rst_drd", d_rdata, 32'h0);
      m_starve = 0;
      m_pend   = 0;
      m_pflush = 1'b0;
    end else begin
      e_drd = (m_pend == 1) ? sram_dout : 32'h0;
      e_ir  = (m_pend == 2) && !m_pflush && !f_flush;
      e_ird = e_ir ? sram_dout : 32'h0;
      e_lv  = (m_pend == 3);
      e_lrd = e_lv ? sram_dout : 32'h0;

      if (d_req) w = 1;
      else if (f_req && m_starve >= STARVE_LIMIT) w = 2;
      else if (ld_req) w = 3;
      else if (f_req) w = 2;
      else w = 0;

      e_cen = (w == 0);
      e_wen = 1'b1; e_ben = 4'hF; e_addr = 0; e_din = 0; e_gnt = 1'b0; rd = 1'b0;
      if (w == 1) begin
        e_wen = ~d_we; e_ben = d_we ? d_ben : 4'h0; e_addr = d_addr;
        e_din = d_we ? d_wdata : 32'h0; rd = !d_we;
      end else if (w == 2) begin
        e_ben = 4'h0; e_addr = f_addr; rd = 1'b1;
      end else if (w == 3) begin
        e_wen = ~ld_we; e_ben = 4'h0; e_addr = ld_addr;
        e_din = ld_we ? ld_wdata : 32'h0; e_gnt = 1'b1; rd = !ld_we;
      end

      chk("cen", sram_cen, e_cen);
      chk("wen", sram_wen, e_wen);
      chk("ben", sram_ben, e_ben);
      chk("addr", sram_addr, e_addr);
      chk("din", sram_din, e_din);
      chk("ld_gnt", ld_gnt, e_gnt);
      chk("d_rdata", d_rdata, e_drd);
      chk("inst_ready", inst_ready, e_ir);
      chk("inst_rdata", inst_rdata, e_ird);
      chk("ld_rvalid", ld_rvalid, e_lv);
      chk("ld_rdata", ld_rdata, e_lrd);

      if (f_req && w != 2) m_starve = (m_starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_starve + 1;
      else m_starve = 0;
      m_pend   = rd ? w : 0;
      m_pflush = f_flush;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d_req = 0; d_we = 0; d_ben = 4'hF; d_addr = 0; d_wdata = 0;
    f_req = 0; f_addr = 0; f_flush = 0;
    ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    sram_dout = 32'h0;
    idle();
    repeat (3) next_cycle();
    #2;
    chk("lit_rst_cen", sram_cen, 1'b1);
    chk("lit_rst_ben", sram_ben, 4'hF);
    next_cycle();
    rst_n = 1'b1;

    // Fetch alone, one-cycle read latency.
    next_cycle();
    f_req = 1; f_addr = 32'h100; sram_dout = 32'h5555_AAAA;
    #2;
    chk("lit_f_cen", sram_cen, 1'b0);
    chk("lit_f_addr", sram_addr, 32'h100);
    next_cycle();
    f_req = 0; sram_dout = 32'h0000_0013;
    #2;
    chk("lit_f_ready", inst_ready, 1'b1);
    chk("lit_f_rdata", inst_rdata, 32'h0000_0013);

    // Data beats concurrent fetch.
    next_cycle();
    d_req = 1; d_addr = 32'h200; f_req = 1; f_addr = 32'h104; sram_dout = 0;
    #2;
    chk("lit_d_addr", sram_addr, 32'h200);
    next_cycle();
    idle(); sram_dout = 32'hCAFE_F00D;
    #2;
    chk("lit_d_rdata", d_rdata, 32'hCAFE_F00D);
    chk("lit_d_ir", inst_ready, 1'b0);
    chk("lit_model_starve1", m_starve, 1);

    // Loader stream vs held fetch: fetch promoted on the fifth cycle.
    next_cycle();
    ld_req = 1; ld_we = 1; ld_addr = 32'h40; ld_wdata = 32'hDEAD_BEEF;
    f_req = 1; f_addr = 32'h10C; sram_dout = 32'h0000_0093;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) next_cycle();
      #2;
      chk("lit_ld_gnt", ld_gnt, (i != 4));
      chk("lit_ld_addr", sram_addr, (i == 4) ? 32'h10C : 32'h40);
      if (i == 4) chk("lit_model_starve4", m_starve, 4);
      if (i == 5) begin
        chk("lit_ld_din", sram_din, 32'hDEAD_BEEF);
        chk("lit_starve_ir", inst_ready, 1'b1);
        chk("lit_model_starve0", m_starve, 0);
      end
    end

    // Flush in the response cycle, then flush in the grant cycle.
    next_cycle();
    idle(); f_req = 1; f_addr = 32'h108;
    next_cycle();
    f_req = 0; f_flush = 1; sram_dout = 32'h0010_0093;
    #2;
    chk("lit_flush_ir", inst_ready, 1'b0);
    chk("lit_flush_rd", inst_rdata, 32'h0);
    next_cycle();
    f_req = 1; f_flush = 1;
    next_cycle();
    f_req = 0; f_flush = 0;
    #2;
    chk("lit_flush2_ir", inst_ready, 1'b0);

    // Partial store, then loader read.
    next_cycle();
    d_req = 1; d_we = 1; d_ben = 4'b1100; d_wdata = 32'h0000_ABCD; d_addr = 32'h300;
    #2;
    chk("lit_st_wen", sram_wen, 1'b0);
    chk("lit_st_ben", sram_ben, 4'b1100);
    chk("lit_st_din", sram_din, 32'h0000_ABCD);
    next_cycle();
    idle(); ld_req = 1; ld_addr = 32'h44; sram_dout = 32'h1234_5678;
    #2;
    chk("lit_st_noresp", {inst_ready, ld_rvalid}, 2'b00);
    chk("lit_st_drd", d_rdata, 32'h0);
    chk("lit_lr_wen", sram_wen, 1'b1);
    next_cycle();
    idle(); sram_dout = 32'h8765_4321;
    #2;
    chk("lit_lr_valid", ld_rvalid, 1'b1);
    chk("lit_lr_data", ld_rdata, 32'h8765_4321);
    chk("lit_idle_cen", sram_cen, 1'b1);

    // Reset asserted during a fetch grant with every request high.
    next_cycle();
    f_req = 1; f_addr = 32'h110;
    next_cycle();
    d_req = 1; d_addr = 32'h204; ld_req = 1; ld_addr = 32'h48; sram_dout = 32'h0000_0013;
    rst_n = 0;
    #1;
    chk("lit_ra_cen", sram_cen, 1'b1);
    chk("lit_ra_ir", inst_ready, 1'b0);
    chk("lit_ra_gnt", ld_gnt, 1'b0);
    next_cycle();
    next_cycle();
    rst_n = 1;
    #2;
    chk("lit_rr_cen", sram_cen, 1'b0);
    chk("lit_rr_addr", sram_addr, 32'h204);
    chk("lit_rr_ir", inst_ready, 1'b0);
    chk("lit_rr_lv", ld_rvalid, 1'b0);
    next_cycle();
    idle();
    repeat (3) next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
